// File: rtl/inst_rom_if.sv
// Fetch and program-load bus of the instruction ROM.
// Slave modport is the ROM side; master modport is the core/loader side.
// Signal names carry the block's port naming so both sides read the same.
interface inst_rom_if #(
  parameter int ADDR_W = 6
);
  logic              inst_rom_ce_i;
  logic [31:0]       inst_rom_addr_in_i;
  logic [31:0]       inst_rom_data_out_o;
  logic              inst_rom_addr_err_o;
  logic              load_start_i;
  logic [ADDR_W:0]   load_len_i;
  logic [7:0]        load_byte_i;
  logic              load_valid_i;
  logic              load_ready_o;
  logic              load_busy_o;
  logic              load_done_o;
  logic [ADDR_W:0]   load_count_o;

  modport slave (
    input  inst_rom_ce_i, inst_rom_addr_in_i, load_start_i, load_len_i,
           load_byte_i, load_valid_i,
    output inst_rom_data_out_o, inst_rom_addr_err_o, load_ready_o,
           load_busy_o, load_done_o, load_count_o
  );

  modport master (
    output inst_rom_ce_i, inst_rom_addr_in_i, load_start_i, load_len_i,
           load_byte_i, load_valid_i,
    input  inst_rom_data_out_o, inst_rom_addr_err_o, load_ready_o,
           load_busy_o, load_done_o, load_count_o
  );
endinterface

// File: rtl/inst_rom.sv
// Instruction ROM (2^ADDR_W x 32) loadable from a big-endian byte stream.
// Latency: fetch is combinational (same cycle); a load word is written on its 4th byte edge.
// Backpressure: load_ready_o is high only in LOAD; bytes are taken on valid && ready.
module inst_rom #(
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  inst_rom_if.slave   bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_W:0]     len;
  logic [ADDR_W:0]     count;
  logic [ADDR_W:0]     len_eff;
  logic [ADDR_W-1:0]   wptr;
  logic [1:0]          byte_cnt;
  logic [23:0]         part;
  logic                ready;
  logic                accept;
  logic                word_last;

  // Zero or oversize lengths mean "fill the whole ROM".
  assign len_eff   = (bus.load_len_i == '0 || bus.load_len_i > DEPTH_W) ? DEPTH_W : bus.load_len_i;
  assign accept    = bus.load_valid_i && ready;
  assign word_last = accept && (byte_cnt == 2'd3) && ((count + ONE_W) == len);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: start only from IDLE, leave LOAD on the last word, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load_start_i) state_nxt = LOAD;
      LOAD:    if (word_last)        state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the state; held low while in reset.
  always_comb begin
    ready            = rst && (state == LOAD);
    bus.load_ready_o = ready;
    bus.load_busy_o  = ready;
    bus.load_done_o  = (state == DONE);
    bus.load_count_o = count;
  end

  // Load datapath: latch length on start, assemble bytes MSB-first, commit on the 4th byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len      <= '0;
      count    <= '0;
      wptr     <= '0;
      byte_cnt <= '0;
      part     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (state == IDLE && bus.load_start_i) begin
      len      <= len_eff;
      count    <= '0;
      wptr     <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      part     <= {part[15:0], bus.load_byte_i};
      if (byte_cnt == 2'd3) begin
        mem[wptr] <= {part, bus.load_byte_i};
        wptr      <= wptr + 1'b1;
        count     <= count + ONE_W;
      end
    end
  end

  // Combinational fetch; misaligned, out-of-range or mid-load reads return a NOP.
  always_comb begin
    bus.inst_rom_addr_err_o = bus.inst_rom_ce_i &&
                              ((bus.inst_rom_addr_in_i[1:0] != 2'b00) ||
                               (bus.inst_rom_addr_in_i[31:ADDR_W+2] != '0));
    bus.inst_rom_data_out_o = 32'h0;
    if (bus.inst_rom_ce_i && state != LOAD && !bus.inst_rom_addr_err_o)
      bus.inst_rom_data_out_o = mem[bus.inst_rom_addr_in_i[ADDR_W+1:2]];
  end
endmodule

// File: tb/tb_inst_rom.sv
// Self-checking bench for inst_rom: loads random programs and compares fetches
// against a word-array reference built directly from the byte stream.
module tb_inst_rom;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  inst_rom_if #(.ADDR_W(AW)) bus();
  inst_rom #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [7:0]  stim [$];

  // results of the last run_load
  int r_acc, r_lat, r_rdy, r_busy;
  bit r_to, r_done_rdy, r_idle_rdy, r_idle_done;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.inst_rom_ce_i      = 1'b0;
    bus.inst_rom_addr_in_i = 32'h0;
    bus.load_start_i       = 1'b0;
    bus.load_len_i         = '0;
    bus.load_byte_i        = 8'h0;
    bus.load_valid_i       = 1'b0;
  endtask

  function automatic int eff_len(input int l);
    return (l == 0 || l > DEPTH) ? DEPTH : l;
  endfunction

  // Reference: the first eff_len words take bytes 4w..4w+3, MSB first; the rest are untouched.
  task automatic model_load(input int l);
    for (int w = 0; w < eff_len(l); w++)
      ref_mem[w] = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
  endtask

  task automatic model_clear();
    for (int w = 0; w < DEPTH; w++) ref_mem[w] = 32'h0;
  endtask

  // Drive one load: mode 0 = valid held, 1 = valid toggles, 2 = random valid and spurious starts.
  task automatic run_load(input int l, input int mode, input int budget);
    int idx  = 0;
    int last = -1;
    bit v;
    r_acc = 0; r_lat = -1; r_rdy = 0; r_busy = 0; r_to = 1'b1;
    bus.load_start_i = 1'b1;
    bus.load_len_i   = l[AW:0];
    tick();
    bus.load_start_i = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (bus.load_done_o === 1'b1) begin
        r_lat = cyc - last;
        r_to  = 1'b0;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.load_valid_i = v && (idx < stim.size());
      bus.load_byte_i  = (idx < stim.size()) ? stim[idx] : 8'h0;
      if (mode == 2) begin
        bus.load_start_i = 1'($urandom_range(0, 1));
        bus.load_len_i   = (AW + 1)'($urandom);
      end
      if (bus.load_ready_o === 1'b1) r_rdy++;
      if (bus.load_busy_o === 1'b1) r_busy++;
      if (bus.load_valid_i && bus.load_ready_o === 1'b1) begin
        idx++; r_acc++; last = cyc;
      end
      tick();
    end
    // DONE cycle (or timeout): keep offering surplus bytes, they must not be taken
    bus.load_start_i = 1'b0;
    bus.load_valid_i = (idx < stim.size());
    bus.load_byte_i  = (idx < stim.size()) ? stim[idx] : 8'h0;
    r_done_rdy = bus.load_ready_o;
    tick();
    r_idle_rdy  = bus.load_ready_o;
    r_idle_done = bus.load_done_o;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick(); tick();
    model_clear();
    n_cmp++; if (bus.load_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", bus.load_ready_o); end
    n_cmp++; if (bus.load_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.load_busy_o); end
    n_cmp++; if (bus.load_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.load_done_o); end
    n_cmp++; if (bus.load_count_o !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", bus.load_count_o); end
    rst = 1'b1;
    tick();
    for (int w = 0; w < DEPTH; w++) begin
      bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'(w * 4); #1;
      n_cmp++;
      if (bus.inst_rom_data_out_o !== ref_mem[w] || bus.inst_rom_addr_err_o !== 1'b0) begin
        n_bad++; $display("FAIL reset_scan w=%0d got %h/%b want %h/0", w, bus.inst_rom_data_out_o, bus.inst_rom_addr_err_o, ref_mem[w]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_basic_load(input int mode, input string tag);
    logic [31:0] exp_w0 = 32'h34010001;
    logic [31:0] exp_w1 = 32'h24020002;
    stim = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h02};
    run_load(2, mode, 100);
    model_load(2);
    n_cmp++; if (r_to) begin n_bad++; $display("FAIL %s_timeout no done within budget", tag); end
    n_cmp++; if (r_acc != 8) begin n_bad++; $display("FAIL %s_accepted got %0d want 8", tag, r_acc); end
    n_cmp++; if (r_lat != 1) begin n_bad++; $display("FAIL %s_done_latency got %0d want 1", tag, r_lat); end
    if (mode == 0) begin
      n_cmp++; if (r_rdy != 8) begin n_bad++; $display("FAIL %s_ready_cycles got %0d want 8", tag, r_rdy); end
      n_cmp++; if (r_busy != 8) begin n_bad++; $display("FAIL %s_busy_cycles got %0d want 8", tag, r_busy); end
    end
    n_cmp++; if (r_done_rdy !== 1'b0 || r_idle_rdy !== 1'b0) begin n_bad++; $display("FAIL %s_ready_after got %b%b want 00", tag, r_done_rdy, r_idle_rdy); end
    n_cmp++; if (r_idle_done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width got %b want 0", tag, r_idle_done); end
    n_cmp++; if (bus.load_count_o !== 7'd2) begin n_bad++; $display("FAIL %s_count got %0d want 2", tag, bus.load_count_o); end
    n_cmp++; if (ref_mem[0] !== exp_w0 || ref_mem[1] !== exp_w1) begin n_bad++; $display("FAIL %s_refmodel got %h %h", tag, ref_mem[0], ref_mem[1]); end
    for (int w = 0; w < 3; w++) begin
      bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'(w * 4); #1;
      n_cmp++;
      if (bus.inst_rom_data_out_o !== ref_mem[w]) begin
        n_bad++; $display("FAIL %s_fetch addr=%h got %h want %h", tag, w * 4, bus.inst_rom_data_out_o, ref_mem[w]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_addr_err();
    logic [31:0] addrs [8] = '{32'h2, 32'h100, 32'h0, 32'h1, 32'h3, 32'hFC, 32'h8000_0000, 32'h4};
    bit          ces   [8] = '{1, 1, 0, 1, 1, 1, 1, 0};
    bit          e_err;
    logic [31:0] e_dat;
    for (int i = 0; i < 8; i++) begin
      bus.inst_rom_ce_i = ces[i]; bus.inst_rom_addr_in_i = addrs[i]; #1;
      e_err = ces[i] && ((addrs[i] % 4 != 0) || (addrs[i] >= 4 * DEPTH));
      e_dat = (ces[i] && !e_err) ? ref_mem[addrs[i] / 4] : 32'h0;
      n_cmp++;
      if (bus.inst_rom_addr_err_o !== e_err || bus.inst_rom_data_out_o !== e_dat) begin
        n_bad++; $display("FAIL addr_err ce=%b addr=%h got %b/%h want %b/%h", ces[i], addrs[i],
                          bus.inst_rom_addr_err_o, bus.inst_rom_data_out_o, e_err, e_dat);
      end
    end
    idle_inputs();
  endtask

  task automatic test_full_load();
    stim.delete();
    for (int i = 0; i < 4 * DEPTH + 4; i++) stim.push_back(8'($urandom));
    run_load(0, 0, 4 * DEPTH + 50);
    model_load(0);
    n_cmp++; if (r_to) begin n_bad++; $display("FAIL full_timeout no done within budget"); end
    n_cmp++; if (r_acc != 4 * DEPTH) begin n_bad++; $display("FAIL full_accepted got %0d want %0d", r_acc, 4 * DEPTH); end
    n_cmp++; if (r_done_rdy !== 1'b0 || r_idle_rdy !== 1'b0) begin n_bad++; $display("FAIL full_ready_after got %b%b want 00", r_done_rdy, r_idle_rdy); end
    n_cmp++; if (bus.load_count_o !== 7'(DEPTH)) begin n_bad++; $display("FAIL full_count got %0d want %0d", bus.load_count_o, DEPTH); end
    for (int w = 0; w < DEPTH; w++) begin
      bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'(w * 4); #1;
      n_cmp++;
      if (bus.inst_rom_data_out_o !== ref_mem[w]) begin
        n_bad++; $display("FAIL full_scan w=%0d got %h want %h", w, bus.inst_rom_data_out_o, ref_mem[w]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midload();
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    bus.load_start_i = 1'b1; bus.load_len_i = 7'd2;
    tick();
    bus.load_start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.load_valid_i = 1'b1; bus.load_byte_i = stim[i];
      tick();
    end
    bus.load_valid_i = 1'b0;
    rst = 1'b0;
    tick();
    model_clear();
    n_cmp++; if (bus.load_busy_o !== 1'b0 || bus.load_ready_o !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b%b want 00", bus.load_busy_o, bus.load_ready_o); end
    n_cmp++; if (bus.load_count_o !== '0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", bus.load_count_o); end
    rst = 1'b1;
    tick();
    bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'h0; #1;
    n_cmp++; if (bus.inst_rom_data_out_o !== 32'h0) begin n_bad++; $display("FAIL midrst_fetch0 got %h want 0", bus.inst_rom_data_out_o); end
    idle_inputs();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
    run_load(1, 0, 50);
    model_load(1);
    n_cmp++; if (r_to || bus.load_count_o !== 7'd1) begin n_bad++; $display("FAIL midrst_reload_count got %0d (timeout %b) want 1", bus.load_count_o, r_to); end
    for (int w = 0; w < 2; w++) begin
      bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'(w * 4); #1;
      n_cmp++;
      if (bus.inst_rom_data_out_o !== ref_mem[w]) begin
        n_bad++; $display("FAIL midrst_reload w=%0d got %h want %h", w, bus.inst_rom_data_out_o, ref_mem[w]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random_loads(input int iters);
    int          l, e;
    logic [31:0] a;
    bit          e_err;
    logic [31:0] e_dat;
    for (int it = 0; it < iters; it++) begin
      l = $urandom_range(0, 127);
      e = eff_len(l);
      stim.delete();
      for (int i = 0; i < 4 * e + $urandom_range(0, 8); i++) stim.push_back(8'($urandom));
      run_load(l, 2, 4 * e * 8 + 100);
      model_load(l);
      n_cmp++; if (r_to) begin n_bad++; $display("FAIL rand%0d_timeout len=%0d", it, l); end
      n_cmp++; if (r_acc != 4 * e) begin n_bad++; $display("FAIL rand%0d_accepted got %0d want %0d", it, r_acc, 4 * e); end
      n_cmp++; if (r_lat != 1) begin n_bad++; $display("FAIL rand%0d_done_latency got %0d want 1", it, r_lat); end
      tick(); tick(); tick();
      n_cmp++; if (bus.load_count_o !== 7'(e)) begin n_bad++; $display("FAIL rand%0d_count got %0d want %0d", it, bus.load_count_o, e); end
      for (int w = 0; w < DEPTH; w++) begin
        bus.inst_rom_ce_i = 1'b1; bus.inst_rom_addr_in_i = 32'(w * 4); #1;
        n_cmp++;
        if (bus.inst_rom_data_out_o !== ref_mem[w]) begin
          n_bad++; $display("FAIL rand%0d_scan w=%0d got %h want %h", it, w, bus.inst_rom_data_out_o, ref_mem[w]);
        end
      end
      for (int k = 0; k < 8; k++) begin
        a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 8));
        bus.inst_rom_ce_i = 1'($urandom_range(0, 3) != 0); bus.inst_rom_addr_in_i = a; #1;
        e_err = bus.inst_rom_ce_i && ((a % 4 != 0) || (a >= 4 * DEPTH));
        e_dat = (bus.inst_rom_ce_i && !e_err) ? ref_mem[a / 4] : 32'h0;
        n_cmp++;
        if (bus.inst_rom_addr_err_o !== e_err || bus.inst_rom_data_out_o !== e_dat) begin
          n_bad++; $display("FAIL rand%0d_fetch addr=%h got %b/%h want %b/%h", it, a,
                            bus.inst_rom_addr_err_o, bus.inst_rom_data_out_o, e_err, e_dat);
        end
      end
      idle_inputs();
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_basic_load(0, "basic");
    test_addr_err();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    model_clear();
    test_basic_load(1, "toggle");
    test_full_load();
    test_addr_err();
    test_reset_midload();
    test_random_loads(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_rom.md
INST_ROM -- requirements
Module: inst_rom

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, giving log2 of the word depth (64 words of 32 bits).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset (rst=0 resets at the clock edge).
REQ-004 SHALL have port inst_rom_ce_i, input, 1 bit: fetch enable from the core PC.
REQ-005 SHALL have port inst_rom_addr_in_i, input, 32 bits: fetch byte address.
REQ-006 SHALL have port inst_rom_data_out_o, output, 32 bits: fetched instruction word.
REQ-007 SHALL have port inst_rom_addr_err_o, output, 1 bit: fetch address misaligned or out of range.
REQ-008 SHALL have port load_start_i, input, 1 bit: begin a program load.
REQ-009 SHALL have port load_len_i, input, ADDR_W+1 bits: number of words to load, sampled at start.
REQ-010 SHALL have port load_byte_i, input, 8 bits: program byte stream.
REQ-011 SHALL have port load_valid_i, input, 1 bit: load_byte_i is valid.
REQ-012 SHALL have port load_ready_o, output, 1 bit: block accepts a byte this cycle.
REQ-013 SHALL have port load_busy_o, output, 1 bit: load in progress.
REQ-014 SHALL have port load_done_o, output, 1 bit: one-cycle pulse when a load completes.
REQ-015 SHALL have port load_count_o, output, ADDR_W+1 bits: words written by the current or last load.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD and DONE, with IDLE as the reset state.
REQ-017 In IDLE, load_start_i=1 SHALL latch len = (load_len_i==0 or load_len_i>2^ADDR_W) ? 2^ADDR_W : load_len_i, clear wptr, byte_cnt and load_count_o, and move to LOAD.
REQ-018 In LOAD, load_ready_o SHALL be 1; it SHALL be 0 in IDLE and DONE.
REQ-019 A byte SHALL be accepted only on a cycle with load_valid_i && load_ready_o; byte_cnt SHALL count 0..3 and wrap.
REQ-020 Words SHALL be assembled big-endian: the first accepted byte goes to [31:24], the fourth to [7:0].
REQ-021 On the fourth byte, the assembled word SHALL be written to mem[wptr] at that same edge, wptr SHALL increment, and load_count_o SHALL increment.
REQ-022 When the written word is number len, the next state SHALL be DONE and no further bytes SHALL be accepted.
REQ-023 DONE SHALL last exactly one cycle with load_done_o=1, then return to IDLE.
REQ-024 load_start_i SHALL be ignored in LOAD and DONE.
REQ-025 load_busy_o SHALL be 1 exactly in LOAD.
REQ-026 load_count_o SHALL hold its value in IDLE until the next start.
REQ-027 Fetch reads SHALL be combinational, same cycle, because the core's IF/ID register samples inst_rom_data_out_o at the next edge.
REQ-028 inst_rom_addr_err_o SHALL be inst_rom_ce_i && (addr[1:0]!=0 || addr[31:ADDR_W+2]!=0).
REQ-029 inst_rom_data_out_o SHALL be mem[addr[ADDR_W+1:2]] when inst_rom_ce_i=1, state!=LOAD and inst_rom_addr_err_o=0; otherwise it SHALL be 32'h0 (NOP).
REQ-030 Reads during LOAD SHALL return 0; there is no read/write collision path.
REQ-031 Writes to the same word in a later load SHALL overwrite it; words beyond len SHALL keep their prior contents.

Reset
REQ-032 On rst=0 at an edge: state=IDLE, and wptr, byte_cnt, len, load_count_o and load_done_o SHALL be 0.
REQ-033 On rst=0 at an edge, every mem word SHALL be 32'h0.
REQ-034 Reset in the middle of a load SHALL discard any partial word.
REQ-035 While rst=0, load_ready_o and load_busy_o SHALL be 0, and inst_rom_data_out_o SHALL still follow REQ-029 (reads return 0).

Verification
REQ-036 Reset, then ce=1, addr=0x0 -> data_out=0x00000000, addr_err=0.
REQ-037 Start with len=2, then bytes 34 01 00 01 24 02 00 02 with valid held 1 -> ready=1 for 8 cycles; done pulses 1 cycle after the 8th byte; count=2; fetch addr 0x0 -> 0x34010001; fetch addr 0x4 -> 0x24020002; fetch addr 0x8 -> 0x0.
REQ-038 Same load with valid toggling 1/0 every cycle -> identical memory contents and count=2; done rises 1 cycle after the 8th accepted byte.
REQ-039 ce=1, addr=0x2 -> addr_err=1, data_out=0; ce=1, addr=0x100 (ADDR_W=6) -> addr_err=1, data_out=0; ce=0, addr=0x0 -> data_out=0, addr_err=0.
REQ-040 len=0 -> loads 64 words; a 65th byte group offered afterwards is not accepted (ready=0 in DONE/IDLE); count=64; fetch 0xFC returns the last word.
REQ-041 Assert rst=0 after 6 bytes of a 2-word load -> state IDLE, busy=0, count=0, fetch 0x0 returns 0; a new start with len=1 loads correctly.
